// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the CPU control path: state codes, control-field
//   encodings and the decoded control word. Used by control_sequencer,
//   control_decode and the next-state block.
package cpu_ctrl_pkg;

    // State codes
    localparam logic [7:0] S_FETCH    = 8'h00;
    localparam logic [7:0] S_DECODE   = 8'h01;
    localparam logic [7:0] S_LOAD     = 8'h02;
    localparam logic [7:0] S_MOV      = 8'h03;
    localparam logic [7:0] S_LDPC     = 8'h04;
    localparam logic [7:0] S_BRANCH   = 8'h05;
    localparam logic [7:0] S_SUB0     = 8'h06;
    localparam logic [7:0] S_SUB1     = 8'h07;
    localparam logic [7:0] S_SUB2     = 8'h08;
    localparam logic [7:0] S_ADD0     = 8'h09;
    localparam logic [7:0] S_ADD1     = 8'h0A;
    localparam logic [7:0] S_ADD2     = 8'h0B;
    localparam logic [7:0] S_XOR0     = 8'h0C;
    localparam logic [7:0] S_XOR1     = 8'h0D;
    localparam logic [7:0] S_XOR2     = 8'h0E;
    localparam logic [7:0] S_LOADIR   = 8'h0F;
    localparam logic [7:0] S_MUL1     = 8'h10;
    localparam logic [7:0] S_MUL2     = 8'h11;
    localparam logic [7:0] S_MUL3     = 8'h12;
    localparam logic [7:0] S_PUSH0    = 8'h13;
    localparam logic [7:0] S_PUSH1    = 8'h14;
    localparam logic [7:0] S_PUSH2    = 8'h15;
    localparam logic [7:0] S_PUSH3    = 8'h16;
    localparam logic [7:0] S_POP0     = 8'h17;
    localparam logic [7:0] S_POP1     = 8'h18;
    localparam logic [7:0] S_POP2     = 8'h19;
    localparam logic [7:0] S_POP3     = 8'h1A;
    localparam logic [7:0] S_CALL0    = 8'h1B;
    localparam logic [7:0] S_CALL1    = 8'h1C;
    localparam logic [7:0] S_CALL2    = 8'h1D;
    localparam logic [7:0] S_CALL3    = 8'h1E;
    localparam logic [7:0] S_CALL4    = 8'h1F;
    localparam logic [7:0] S_CALL5    = 8'h20;
    localparam logic [7:0] S_RET0     = 8'h21;
    localparam logic [7:0] S_RET1     = 8'h22;
    localparam logic [7:0] S_RET2     = 8'h23;
    localparam logic [7:0] S_RET3     = 8'h24;
    localparam logic [7:0] S_CMP0     = 8'h26;
    localparam logic [7:0] S_CMP1     = 8'h27;
    localparam logic [7:0] S_MUL0     = 8'h28;
    localparam logic [7:0] S_BR0      = 8'h29;
    localparam logic [7:0] S_BR_TAKEN = 8'h2A;
    localparam logic [7:0] S_BR2      = 8'h2B;
    localparam logic [7:0] S_BR3      = 8'h2C;
    localparam logic [7:0] S_BR4      = 8'h2D;
    localparam logic [7:0] S_BR_EVAL0 = 8'h2E;
    localparam logic [7:0] S_BR_EVAL1 = 8'h2F;
    localparam logic [7:0] S_CALL6    = 8'h4A;

    // addr_sel
    localparam logic [1:0] ADDR_PC = 2'd0;
    localparam logic [1:0] ADDR_SP = 2'd1;

    // mem_wdata_sel
    localparam logic MWD_REG = 1'b0;
    localparam logic MWD_PC  = 1'b1;

    // wdata_sel
    localparam logic [2:0] WD_IMM = 3'd0;
    localparam logic [2:0] WD_REG = 3'd1;
    localparam logic [2:0] WD_ALU = 3'd2;
    localparam logic [2:0] WD_PC  = 3'd3;
    localparam logic [2:0] WD_MEM = 3'd4;

    // pc_src
    localparam logic PC_SRC_REG = 1'b0;
    localparam logic PC_SRC_MEM = 1'b1;

    // alu_op
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_XOR = 2'd2;
    localparam logic [1:0] ALU_MUL = 2'd3;

    // Full set of strobes decoded from one state
    typedef struct packed {
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] addr_sel;
        logic       mem_wdata_sel;
        logic       pc_inc;
        logic       pc_load;
        logic       pc_src;
        logic       sp_inc;
        logic       sp_dec;
        logic       reg_we;
        logic [2:0] wdata_sel;
        logic [1:0] alu_op;
        logic       a_load;
        logic       b_load;
        logic       status_we;
        logic       ir_load;
    } ctrl_t;

    // True for every state code the sequencer knows how to decode
    function automatic logic is_defined_state(input logic [7:0] s);
        case (s) inside
            [8'h00:8'h24], [8'h26:8'h2F], 8'h4A: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// control_decode
//   Purely combinational decode of the current state (and instruction
//   register fields) into the datapath control word.
//   Ports:
//     state     in  8  current state
//     instr     in 16  instruction register
//     mem_ready in  1  memory access completes this cycle
//     ctrl      out    decoded control word
//     rd_sel    out 4  instr[11:8]
//     rs_sel    out 4  instr[7:4]
module control_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [7:0]  state,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    output ctrl_t       ctrl,
    output logic [3:0]  rd_sel,
    output logic [3:0]  rs_sel
);

    assign rd_sel = instr[11:8];
    assign rs_sel = instr[7:4];

    // Three-phase ALU family: operand A latch, operand B latch, write-back.
    // alu_op stays on the family's operation in every phase.
    function automatic ctrl_t alu_phase(input logic [1:0] op, input logic [1:0] phase);
        ctrl_t c;
        c        = '0;
        c.alu_op = op;
        case (phase)
            2'd0:    c.a_load = 1'b1;
            2'd1:    c.b_load = 1'b1;
            2'd2: begin
                c.reg_we    = 1'b1;
                c.wdata_sel = WD_ALU;
                c.status_we = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

    always_comb begin
        // NOTE: defaulting the whole word first keeps every path assigned, so
        // no latch is inferred and unlisted states decode to all-zero.
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_rd   = 1'b1;
                ctrl.addr_sel = ADDR_PC;
            end
            S_LOADIR: begin
                ctrl.mem_rd   = 1'b1;
                ctrl.addr_sel = ADDR_PC;
                ctrl.ir_load  = mem_ready;
                ctrl.pc_inc   = mem_ready;
            end
            S_LOAD: begin
                ctrl.reg_we    = 1'b1;
                ctrl.wdata_sel = WD_IMM;
            end
            S_MOV: begin
                ctrl.reg_we    = 1'b1;
                ctrl.wdata_sel = WD_REG;
            end
            S_LDPC: begin
                ctrl.reg_we    = 1'b1;
                ctrl.wdata_sel = WD_PC;
            end
            S_BRANCH, S_CALL4, S_BR_TAKEN: begin
                ctrl.pc_load = 1'b1;
                ctrl.pc_src  = PC_SRC_REG;
            end
            S_ADD0: ctrl = alu_phase(ALU_ADD, 2'd0);
            S_ADD1: ctrl = alu_phase(ALU_ADD, 2'd1);
            S_ADD2: ctrl = alu_phase(ALU_ADD, 2'd2);
            S_SUB0: ctrl = alu_phase(ALU_SUB, 2'd0);
            S_SUB1: ctrl = alu_phase(ALU_SUB, 2'd1);
            S_SUB2: ctrl = alu_phase(ALU_SUB, 2'd2);
            S_XOR0: ctrl = alu_phase(ALU_XOR, 2'd0);
            S_XOR1: ctrl = alu_phase(ALU_XOR, 2'd1);
            S_XOR2: ctrl = alu_phase(ALU_XOR, 2'd2);
            S_MUL0: ctrl = alu_phase(ALU_MUL, 2'd0);
            S_MUL1: ctrl = alu_phase(ALU_MUL, 2'd1);
            S_MUL2: ctrl = alu_phase(ALU_MUL, 2'd2);
            S_CMP0: begin
                ctrl.a_load = 1'b1;
                ctrl.b_load = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            S_CMP1: begin
                ctrl.status_we = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
            S_PUSH0, S_CALL0: ctrl.sp_dec = 1'b1;
            S_PUSH2: begin
                ctrl.mem_wr        = 1'b1;
                ctrl.addr_sel      = ADDR_SP;
                ctrl.mem_wdata_sel = MWD_REG;
            end
            S_CALL2: begin
                ctrl.mem_wr        = 1'b1;
                ctrl.addr_sel      = ADDR_SP;
                ctrl.mem_wdata_sel = MWD_PC;
            end
            S_POP0, S_RET0: begin
                ctrl.mem_rd   = 1'b1;
                ctrl.addr_sel = ADDR_SP;
            end
            S_POP1: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.addr_sel  = ADDR_SP;
                ctrl.reg_we    = mem_ready;
                ctrl.wdata_sel = mem_ready ? WD_MEM : WD_IMM;
            end
            S_RET1: begin
                ctrl.mem_rd   = 1'b1;
                ctrl.addr_sel = ADDR_SP;
                ctrl.pc_load  = mem_ready;
                ctrl.pc_src   = mem_ready ? PC_SRC_MEM : PC_SRC_REG;
            end
            S_POP2, S_RET2: ctrl.sp_inc = 1'b1;
            // Remaining defined states carry no controls; undefined states
            // also land here and are flagged by the sequencer.
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer
//   Holds the CPU state and instruction registers, stalls on memory wait,
//   flags undefined states and exposes the decoded datapath controls.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     next_state   in  8  successor state from the next-state block
//     mem_data     in 16  memory read data
//     mem_ready    in  1  memory access completes this cycle
//     state        out 8  current state register
//     instr        out 16 instruction register
//     rd_sel/rs_sel out 4 instr[11:8] / instr[7:4]
//     memory, PC, SP, register-file and ALU strobes (see cpu_ctrl_pkg)
//     illegal      out 1  sticky undefined-state flag
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  next_state,
    input  logic [15:0] mem_data,
    input  logic        mem_ready,
    output logic [7:0]  state,
    output logic [15:0] instr,
    output logic [3:0]  rd_sel,
    output logic [3:0]  rs_sel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [1:0]  addr_sel,
    output logic        mem_wdata_sel,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        pc_src,
    output logic        sp_inc,
    output logic        sp_dec,
    output logic        reg_we,
    output logic [2:0]  wdata_sel,
    output logic [1:0]  alu_op,
    output logic        a_load,
    output logic        b_load,
    output logic        status_we,
    output logic        illegal
);

    ctrl_t ctrl;
    logic  stall;

    control_decode u_decode (
        .state     (state),
        .instr     (instr),
        .mem_ready (mem_ready),
        .ctrl      (ctrl),
        .rd_sel    (rd_sel),
        .rs_sel    (rs_sel)
    );

    // A memory access in flight freezes the sequence until it completes.
    assign stall = (ctrl.mem_rd | ctrl.mem_wr) & ~mem_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            instr   <= '0;
            illegal <= 1'b0;
        end else begin
            if (!stall) begin
                state <= next_state;
                // Raised on the edge that enters the undefined state, so it is
                // already visible while the sequencer sits there.
                if (!is_defined_state(next_state)) begin
                    illegal <= 1'b1;
                end
            end
            if (ctrl.ir_load) begin
                instr <= mem_data;
            end
        end
    end

    assign mem_rd        = ctrl.mem_rd;
    assign mem_wr        = ctrl.mem_wr;
    assign addr_sel      = ctrl.addr_sel;
    assign mem_wdata_sel = ctrl.mem_wdata_sel;
    assign pc_inc        = ctrl.pc_inc;
    assign pc_load       = ctrl.pc_load;
    assign pc_src        = ctrl.pc_src;
    assign sp_inc        = ctrl.sp_inc;
    assign sp_dec        = ctrl.sp_dec;
    assign reg_we        = ctrl.reg_we;
    assign wdata_sel     = ctrl.wdata_sel;
    assign alu_op        = ctrl.alu_op;
    assign a_load        = ctrl.a_load;
    assign b_load        = ctrl.b_load;
    assign status_we     = ctrl.status_we;

endmodule
